// File: rtl/ttl_jk_pkg.sv
// Shared definitions for the 74109 J/Kn bank sequencer: per-bit codes, FSM states and
// the flip-flop next-state function.
package ttl_jk_pkg;

   localparam logic [1:0] JK_CLEAR  = 2'b00;
   localparam logic [1:0] JK_HOLD   = 2'b01;
   localparam logic [1:0] JK_TOGGLE = 2'b10;
   localparam logic [1:0] JK_SET    = 2'b11;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} seq_state_e;

   function automatic logic jk_next(input logic q, input logic j, input logic kn);
      logic nxt;
      case ({j, kn})
         JK_CLEAR:  nxt = 1'b0;
         JK_HOLD:   nxt = q;
         JK_TOGGLE: nxt = ~q;
         default:   nxt = 1'b1;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/rr_arbiter_mask.sv
// Combinational round-robin pick: first eligible requester at or above ptr, with wrap,
// skipping the one-hot excluded client.
module rr_arbiter_mask #(
   parameter int unsigned NumReq = 4,
   parameter int unsigned IdxW   = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] req,
   input  logic [IdxW-1:0]   ptr,
   input  logic [NumReq-1:0] exclude,
   output logic              valid,
   output logic [IdxW-1:0]   index
);

   logic [NumReq-1:0] eligible;
   logic [IdxW-1:0]   pos;

   assign eligible = req & ~exclude;

   always_comb begin
      valid = 1'b0;
      index = '0;
      pos   = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         pos = IdxW'((32'(ptr) + i) % NumReq);
         if (!valid && eligible[pos]) begin
            valid = 1'b1;
            index = pos;
         end
      end
   end

endmodule

// File: rtl/ttl_jk_bank_sequencer.sv
// Time-shares one 74109 J/Kn flip-flop bank among several clients: arbitrate, present the
// granted J/Kn vector, strobe the bank clock, acknowledge, and track the bank state.
module ttl_jk_bank_sequencer
   import ttl_jk_pkg::*;
#(
   parameter int unsigned BLOCKS     = 2,
   parameter int unsigned REQUESTERS = 4,
   parameter int unsigned DELAY_RISE = 0,
   parameter int unsigned DELAY_FALL = 0
) (
   input  logic                           Clk,
   input  logic                           Clear_bar,
   input  logic [REQUESTERS-1:0]          Req,
   input  logic [REQUESTERS*BLOCKS-1:0]   Cmd_J,
   input  logic [REQUESTERS*BLOCKS-1:0]   Cmd_Kn,
   output logic [REQUESTERS-1:0]          Ack,
   output logic [$clog2(REQUESTERS)-1:0]  Grant_id,
   output logic                           Busy,
   output logic [BLOCKS-1:0]              Ff_J,
   output logic [BLOCKS-1:0]              Ff_Kn,
   output logic                           Ff_clk,
   output logic [BLOCKS-1:0]              Q_shadow
);

   localparam int unsigned IdxW = $clog2(REQUESTERS);

   seq_state_e          state_q, state_d;
   logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]     grant_id_q, grant_id_d;
   logic [BLOCKS-1:0]   ff_j_q, ff_j_d;
   logic [BLOCKS-1:0]   ff_kn_q, ff_kn_d;
   logic                ff_clk_q, ff_clk_d;
   logic [BLOCKS-1:0]   q_shadow_q, q_shadow_d;

   logic [IdxW-1:0]       ptr_after, arb_ptr, arb_idx;
   logic [REQUESTERS-1:0] arb_excl;
   logic                  arb_valid, grant_en;

   assign ptr_after = (grant_id_q == IdxW'(REQUESTERS - 1)) ? '0 : grant_id_q + 1'b1;
   assign arb_ptr   = (state_q == DONE) ? ptr_after : rr_ptr_q;

   // The client being acked may still hold Req this cycle; it must not win again.
   always_comb begin
      arb_excl = '0;
      if (state_q == DONE) arb_excl[grant_id_q] = 1'b1;
   end

   rr_arbiter_mask #(
      .NumReq (REQUESTERS),
      .IdxW   (IdxW)
   ) u_arb (
      .req     (Req),
      .ptr     (arb_ptr),
      .exclude (arb_excl),
      .valid   (arb_valid),
      .index   (arb_idx)
   );

   assign grant_en = arb_valid && (state_q == IDLE || state_q == DONE);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      ff_j_d     = ff_j_q;
      ff_kn_d    = ff_kn_q;
      q_shadow_d = q_shadow_q;
      unique case (state_q)
         IDLE:   state_d = IDLE;
         SETUP:  state_d = STROBE;
         STROBE: state_d = DONE;
         DONE: begin
            state_d  = IDLE;
            rr_ptr_d = ptr_after;
            for (int unsigned b = 0; b < BLOCKS; b++) begin
               q_shadow_d[b] = jk_next(q_shadow_q[b], ff_j_q[b], ff_kn_q[b]);
            end
         end
      endcase
      if (grant_en) begin
         state_d    = SETUP;
         grant_id_d = arb_idx;
         ff_j_d     = Cmd_J[arb_idx*BLOCKS +: BLOCKS];
         ff_kn_d    = Cmd_Kn[arb_idx*BLOCKS +: BLOCKS];
      end
      ff_clk_d = (state_d == STROBE);
   end

   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         ff_j_q     <= '0;
         ff_kn_q    <= '1;
         ff_clk_q   <= 1'b0;
         q_shadow_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         ff_j_q     <= ff_j_d;
         ff_kn_q    <= ff_kn_d;
         ff_clk_q   <= ff_clk_d;
         q_shadow_q <= q_shadow_d;
      end
   end

   always_comb begin
      Ack = '0;
      if (state_q == DONE) Ack[grant_id_q] = 1'b1;
   end

   assign Grant_id = grant_id_q;
   assign Busy     = (state_q != IDLE);
   assign Q_shadow = q_shadow_q;

   // Bank-facing pins carry the board propagation delay; the zero case stays delay-free.
   if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_pins
      assign Ff_clk = ff_clk_q;
      assign Ff_J   = ff_j_q;
      assign Ff_Kn  = ff_kn_q;
   end else begin : g_pins_dly
      assign #(DELAY_RISE, DELAY_FALL) Ff_clk = ff_clk_q;
      assign #(DELAY_RISE, DELAY_FALL) Ff_J   = ff_j_q;
      assign #(DELAY_RISE, DELAY_FALL) Ff_Kn  = ff_kn_q;
   end

endmodule

// File: tb/tb_ttl_jk_bank_sequencer.sv
// Bench for ttl_jk_bank_sequencer: Ack scoreboard, independent 74109 bank model, scenario tasks.
module tb_ttl_jk_bank_sequencer;

   logic       clk = 1'b0;
   logic       clear_bar = 1'b0;
   logic [3:0] req = '0;
   logic [7:0] cmd_j = '0;
   logic [7:0] cmd_kn = '1;
   logic [3:0] ack;
   logic [1:0] grant_id;
   logic       busy;
   logic [1:0] ff_j, ff_kn, q_shadow;
   logic       ff_clk;
   logic [1:0] bank_q;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0] ack;
      int         cyc;
   } obs_t;

   obs_t       obs_q[$];
   logic [3:0] exp_q[$];

   ttl_jk_bank_sequencer #(
      .BLOCKS     (2),
      .REQUESTERS (4),
      .DELAY_RISE (0),
      .DELAY_FALL (0)
   ) dut (
      .Clk       (clk),
      .Clear_bar (clear_bar),
      .Req       (req),
      .Cmd_J     (cmd_j),
      .Cmd_Kn    (cmd_kn),
      .Ack       (ack),
      .Grant_id  (grant_id),
      .Busy      (busy),
      .Ff_J      (ff_j),
      .Ff_Kn     (ff_kn),
      .Ff_clk    (ff_clk),
      .Q_shadow  (q_shadow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ack !== 4'b0000) obs_q.push_back('{ack, cyc});
   end

   // 74109 truth table: {J,Kn} 00 clear, 01 hold, 10 toggle, 11 set.
   function automatic logic bank_next(input logic q, input logic j, input logic kn);
      logic r;
      case ({j, kn})
         2'b00:   r = 1'b0;
         2'b01:   r = q;
         2'b10:   r = ~q;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   always @(posedge ff_clk or negedge clear_bar) begin
      if (!clear_bar) bank_q <= '0;
      else begin
         for (int b = 0; b < 2; b++) bank_q[b] <= bank_next(bank_q[b], ff_j[b], ff_kn[b]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_obs(input int budget, output bit timed_out);
      int n = 0;
      #1;
      while (obs_q.size() == 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      timed_out = (obs_q.size() == 0);
   endtask

   task automatic test_reset();
      clear_bar = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ack); end
      n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_chk++; if (ff_clk !== 1'b0) begin n_fail++; $display("FAIL reset_ff_clk: got %b want 0", ff_clk); end
      n_chk++; if (ff_j !== 2'b00) begin n_fail++; $display("FAIL reset_ff_j: got %b want 00", ff_j); end
      n_chk++; if (ff_kn !== 2'b11) begin n_fail++; $display("FAIL reset_ff_kn: got %b want 11", ff_kn); end
      n_chk++; if (q_shadow !== 2'b00) begin n_fail++; $display("FAIL reset_q_shadow: got %b want 00", q_shadow); end
      step();
      clear_bar = 1'b1;
      step();
   endtask

   task automatic test_single();
      int k;
      bit to;
      obs_t o;
      logic [3:0] e;
      obs_q.delete(); exp_q.delete();
      cmd_j = '0; cmd_kn = '1;
      req = 4'b0001; cmd_j[1:0] = 2'b11; cmd_kn[1:0] = 2'b11;
      k = cyc;
      exp_q.push_back(4'b0001);
      @(negedge clk);
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b want 0", busy); end
      step();
      @(negedge clk);
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_setup: got %b want 1", busy); end
      n_chk++; if (ff_clk !== 1'b0) begin n_fail++; $display("FAIL single_clk_setup: got %b want 0", ff_clk); end
      n_chk++; if (ff_j !== 2'b11 || ff_kn !== 2'b11) begin n_fail++; $display("FAIL single_latch: got J=%b Kn=%b want 11/11", ff_j, ff_kn); end
      step();
      @(negedge clk);
      n_chk++; if (ff_clk !== 1'b1) begin n_fail++; $display("FAIL single_strobe: got %b want 1", ff_clk); end
      step();
      req = 4'b0000;
      @(negedge clk);
      n_chk++; if (ff_clk !== 1'b0) begin n_fail++; $display("FAIL single_clk_done: got %b want 0", ff_clk); end
      wait_obs(20, to);
      n_chk++;
      if (to) begin
         e = exp_q.pop_front();
         n_fail++; $display("FAIL single_ack: got none want %b", e);
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.ack !== e) begin n_fail++; $display("FAIL single_ack: got %b want %b", o.ack, e); end
         n_chk++; if (o.cyc !== k + 3) begin n_fail++; $display("FAIL single_ack_cycle: got %0d want %0d", o.cyc, k + 3); end
      end
      step();
      @(negedge clk);
      n_chk++; if (q_shadow !== 2'b11) begin n_fail++; $display("FAIL single_q: got %b want 11", q_shadow); end
      n_chk++; if (bank_q !== 2'b11) begin n_fail++; $display("FAIL single_bank: got %b want 11", bank_q); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_toggle_hold();
      int k;
      bit to;
      obs_t o;
      logic [3:0] e;
      obs_q.delete(); exp_q.delete();
      step();
      cmd_j = '0; cmd_kn = '1;
      // bit1 toggles 1->0, bit0 holds at 1
      req = 4'b0100; cmd_j[5:4] = 2'b10; cmd_kn[5:4] = 2'b01;
      k = cyc;
      exp_q.push_back(4'b0100);
      repeat (3) step();
      req = 4'b0000;
      wait_obs(20, to);
      n_chk++;
      if (to) begin
         e = exp_q.pop_front();
         n_fail++; $display("FAIL toggle_ack: got none want %b", e);
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.ack !== e) begin n_fail++; $display("FAIL toggle_ack: got %b want %b", o.ack, e); end
         n_chk++; if (o.cyc !== k + 3) begin n_fail++; $display("FAIL toggle_ack_cycle: got %0d want %0d", o.cyc, k + 3); end
      end
      step();
      @(negedge clk);
      n_chk++; if (q_shadow !== 2'b01) begin n_fail++; $display("FAIL toggle_q: got %b want 01", q_shadow); end
      n_chk++; if (bank_q !== q_shadow) begin n_fail++; $display("FAIL toggle_bank: bank %b shadow %b want equal", bank_q, q_shadow); end
   endtask

   task automatic test_back_to_back();
      int k;
      int busy_low = 0;
      bit to;
      obs_t o;
      logic [3:0] e;
      step();
      clear_bar = 1'b0;
      step();
      clear_bar = 1'b1;
      step();
      obs_q.delete(); exp_q.delete();
      cmd_j = '0; cmd_kn = '1;
      req = 4'b1111;
      k = cyc;
      exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
      for (int i = 1; i <= 15; i++) begin
         step();
         if (i == 15) req = 4'b0000;
         @(negedge clk);
         if (busy !== 1'b1) busy_low++;
      end
      n_chk++; if (busy_low !== 0) begin n_fail++; $display("FAIL b2b_busy: got %0d low cycles want 0", busy_low); end
      for (int n = 0; n < 5; n++) begin
         wait_obs(20, to);
         n_chk++;
         if (to) begin
            e = exp_q.pop_front();
            n_fail++; $display("FAIL b2b_ack%0d: got none want %b", n, e);
         end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.ack !== e) begin n_fail++; $display("FAIL b2b_ack%0d: got %b want %b", n, o.ack, e); end
            n_chk++;
            if (o.cyc !== k + 3 * (n + 1)) begin
               n_fail++; $display("FAIL b2b_cycle%0d: got %0d want %0d", n, o.cyc, k + 3 * (n + 1));
            end
         end
      end
      step();
      @(negedge clk);
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", busy); end
   endtask

   task automatic test_fairness();
      int k;
      bit to;
      obs_t o;
      logic [3:0] e;
      obs_q.delete(); exp_q.delete();
      step();
      cmd_j = '0; cmd_kn = '1;
      // Pointer sits at 1; client 1 keeps requesting through its own Ack while 3 waits.
      req = 4'b1010;
      k = cyc;
      exp_q.push_back(4'b0010); exp_q.push_back(4'b1000); exp_q.push_back(4'b0010);
      for (int i = 1; i <= 9; i++) begin
         step();
         if (i == 6) req[3] = 1'b0;
         if (i == 9) req = 4'b0000;
      end
      for (int n = 0; n < 3; n++) begin
         wait_obs(20, to);
         n_chk++;
         if (to) begin
            e = exp_q.pop_front();
            n_fail++; $display("FAIL fair_ack%0d: got none want %b", n, e);
         end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.ack !== e) begin n_fail++; $display("FAIL fair_ack%0d: got %b want %b", n, o.ack, e); end
            n_chk++;
            if (o.cyc !== k + 3 * (n + 1)) begin
               n_fail++; $display("FAIL fair_cycle%0d: got %0d want %0d", n, o.cyc, k + 3 * (n + 1));
            end
         end
      end
   endtask

   task automatic test_reset_in_strobe();
      int k;
      bit to;
      obs_t o;
      logic [3:0] e;
      obs_q.delete(); exp_q.delete();
      step();
      cmd_j = '0; cmd_kn = '1;
      req = 4'b0001; cmd_j[1:0] = 2'b11; cmd_kn[1:0] = 2'b10;
      k = cyc;
      step();
      step();
      @(negedge clk);
      n_chk++; if (ff_clk !== 1'b1) begin n_fail++; $display("FAIL rst_strobe_clk: got %b want 1", ff_clk); end
      #1;
      clear_bar = 1'b0;
      req = 4'b0101;
      #1;
      n_chk++; if (ff_clk !== 1'b0) begin n_fail++; $display("FAIL rst_ff_clk: got %b want 0", ff_clk); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_chk++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rst_ack: got %b want 0000", ack); end
      n_chk++; if (ff_j !== 2'b00 || ff_kn !== 2'b11) begin n_fail++; $display("FAIL rst_ff_jkn: got J=%b Kn=%b want 00/11", ff_j, ff_kn); end
      n_chk++; if (q_shadow !== 2'b00) begin n_fail++; $display("FAIL rst_q: got %b want 00", q_shadow); end
      n_chk++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL rst_no_ack: got %0d acks want 0", obs_q.size()); end
      #1;
      clear_bar = 1'b1;
      // From pointer 0, client 0 precedes client 2.
      exp_q.push_back(4'b0001); exp_q.push_back(4'b0100);
      for (int i = 3; i <= 8; i++) begin
         step();
         if (i == 5) req[0] = 1'b0;
         if (i == 8) req = 4'b0000;
      end
      for (int n = 0; n < 2; n++) begin
         wait_obs(20, to);
         n_chk++;
         if (to) begin
            e = exp_q.pop_front();
            n_fail++; $display("FAIL rst_regrant%0d: got none want %b", n, e);
         end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.ack !== e) begin n_fail++; $display("FAIL rst_regrant%0d: got %b want %b", n, o.ack, e); end
            n_chk++;
            if (o.cyc !== k + 5 + 3 * n) begin
               n_fail++; $display("FAIL rst_regrant_cycle%0d: got %0d want %0d", n, o.cyc, k + 5 + 3 * n);
            end
         end
      end
      step();
      @(negedge clk);
      n_chk++; if (q_shadow !== 2'b11) begin n_fail++; $display("FAIL rst_final_q: got %b want 11", q_shadow); end
      n_chk++; if (bank_q !== 2'b11) begin n_fail++; $display("FAIL rst_final_bank: got %b want 11", bank_q); end
   endtask

   task automatic test_cmd_latch();
      int k;
      bit to;
      obs_t o;
      logic [3:0] e;
      obs_q.delete(); exp_q.delete();
      step();
      cmd_j = '0; cmd_kn = '1;
      // bit1 clears, bit0 holds: 11 -> 01
      req = 4'b0001; cmd_j[1:0] = 2'b00; cmd_kn[1:0] = 2'b01;
      k = cyc;
      exp_q.push_back(4'b0001);
      step();
      cmd_j[1:0] = 2'b11;
      @(negedge clk);
      n_chk++; if (ff_j !== 2'b00) begin n_fail++; $display("FAIL latch_setup_j: got %b want 00", ff_j); end
      step();
      @(negedge clk);
      n_chk++; if (ff_j !== 2'b00 || ff_kn !== 2'b01) begin n_fail++; $display("FAIL latch_strobe_jkn: got J=%b Kn=%b want 00/01", ff_j, ff_kn); end
      step();
      req = 4'b0000;
      wait_obs(20, to);
      n_chk++;
      if (to) begin
         e = exp_q.pop_front();
         n_fail++; $display("FAIL latch_ack: got none want %b", e);
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.ack !== e) begin n_fail++; $display("FAIL latch_ack: got %b want %b", o.ack, e); end
         n_chk++; if (o.cyc !== k + 3) begin n_fail++; $display("FAIL latch_ack_cycle: got %0d want %0d", o.cyc, k + 3); end
      end
      step();
      @(negedge clk);
      n_chk++; if (q_shadow !== 2'b01) begin n_fail++; $display("FAIL latch_q: got %b want 01", q_shadow); end
      n_chk++; if (bank_q !== 2'b01) begin n_fail++; $display("FAIL latch_bank: got %b want 01", bank_q); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_toggle_hold();
      test_back_to_back();
      test_fairness();
      test_reset_in_strobe();
      test_cmd_latch();
      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "watchdog");
   end

endmodule
